axis_baser_tx_arb: RTL and testbench

- Frame-aware round-robin arbiter that shares one 64-bit 10GBASE-R transmit path (axis_baser_tx_64) between S_COUNT AXI4-Stream sources.
- Grants a whole frame at a time and never interleaves beats of different frames.
- Output is registered and connects directly to the transmitter's s_axis input.
- Gates new grants with tx_enable and reports grant and frame status.

---
 rtl/axis_baser_tx_arb.sv | 134 +++++++++++++
 tb/tb_axis_baser_tx_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_baser_tx_arb.sv
// Frame-aware round-robin arbiter feeding one 64-bit BASE-R transmit path.
// State | meaning:  IDLE | pick next requester   XFER | forward granted frame
module axis_baser_tx_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int S_COUNT    = 4,
    parameter int CL_S       = (S_COUNT > 1 ? $clog2(S_COUNT) : 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          tx_enable,
    output logic                          grant_valid,
    output logic [CL_S-1:0]               grant_index,
    output logic [31:0]                   frame_count
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state_q;
    logic [CL_S-1:0]       last_grant_q;
    logic [CL_S-1:0]       grant_index_q;
    logic                  grant_valid_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [KEEP_WIDTH-1:0] tkeep_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  tuser_q;
    logic [31:0]           frame_count_q;

    logic                  any_req;
    logic [CL_S-1:0]       pick;
    logic [CL_S:0]         cand;
    logic                  src_ready;
    logic                  src_hs;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [KEEP_WIDTH-1:0] sel_tkeep;
    logic                  sel_tlast;
    logic                  sel_tuser;

    // Walk downward so the nearest index after last_grant is the last one written.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int k = S_COUNT; k >= 1; k--) begin
            cand = {1'b0, last_grant_q} + (CL_S+1)'(k);
            if (cand >= (CL_S+1)'(S_COUNT)) begin
                cand = cand - (CL_S+1)'(S_COUNT);
            end
            if (s_axis_tvalid[cand[CL_S-1:0]]) begin
                any_req = 1'b1;
                pick    = cand[CL_S-1:0];
            end
        end
    end

    assign src_ready = (state_q == XFER) && (!tvalid_q || m_axis_tready);
    assign src_hs    = src_ready && s_axis_tvalid[grant_index_q];
    assign sel_tdata = s_axis_tdata[int'(grant_index_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tkeep = s_axis_tkeep[int'(grant_index_q)*KEEP_WIDTH +: KEEP_WIDTH];
    assign sel_tlast = s_axis_tlast[grant_index_q];
    assign sel_tuser = s_axis_tuser[grant_index_q];

    assign s_axis_tready = src_ready ? (S_COUNT'(1) << grant_index_q) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= CL_S'(S_COUNT - 1);
            grant_index_q <= '0;
            grant_valid_q <= 1'b0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (src_hs) begin
                tdata_q  <= sel_tdata;
                tkeep_q  <= sel_tkeep;
                tlast_q  <= sel_tlast;
                tuser_q  <= sel_tuser;
                tvalid_q <= 1'b1;
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            if (tvalid_q && m_axis_tready && tlast_q) begin
                frame_count_q <= frame_count_q + 32'd1;
            end

            case (state_q)
                IDLE: begin
                    if (tx_enable && any_req) begin
                        grant_index_q <= pick;
                        last_grant_q  <= pick;
                        grant_valid_q <= 1'b1;
                        state_q       <= XFER;
                    end
                end
                XFER: begin
                    if (src_hs && sel_tlast) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign grant_valid   = grant_valid_q;
    assign grant_index   = grant_index_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_baser_tx_arb.sv
// Bench for axis_baser_tx_arb: queued random frames per source, checked cycle by
// cycle against a frame-level round-robin model of grants, outputs and frame count.
module tb_axis_baser_tx_arb;
    localparam int S  = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [S*DW-1:0]   s_axis_tdata;
    logic [S*KW-1:0]   s_axis_tkeep;
    logic [S-1:0]      s_axis_tvalid;
    logic [S-1:0]      s_axis_tready;
    logic [S-1:0]      s_axis_tlast;
    logic [S-1:0]      s_axis_tuser;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              tx_enable;
    logic              grant_valid;
    logic [1:0]        grant_index;
    logic [31:0]       frame_count;

    axis_baser_tx_arb #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .S_COUNT(S)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .tx_enable(tx_enable), .grant_valid(grant_valid),
        .grant_index(grant_index), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    beat_t srcq [S][$];
    bit    held [S];
    bit    bp [$];
    bit    rand_rdy, rand_gaps, rand_txen;
    int    errors = 0;
    int    checks = 0;

    bit          m_busy, mo_valid;
    int          m_owner, m_last;
    beat_t       mo;
    logic [31:0] exp_fc;
    int          out_beats = 0;
    int          grant_log [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [S-1:0] req);
        for (int k = 1; k <= S; k++) begin
            if (req[(last + k) % S]) return (last + k) % S;
        end
        return -1;
    endfunction

    function automatic bit any_q();
        for (int i = 0; i < S; i++) if (srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input int s, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'($urandom);
            b.last = (k == len - 1);
            b.user = 1'($urandom_range(0, 1));
            srcq[s].push_back(b);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < S; i++) begin
            srcq[i].delete();
            held[i] = 1'b0;
        end
        bp.delete();
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_busy   = 1'b0;
        m_last   = S - 1;
        m_owner  = 0;
        mo_valid = 1'b0;
        exp_fc   = '0;
    endtask

    // One clock: drive at negedge, check 1 ns later, advance model, step to next negedge.
    task automatic cycle();
        logic [S-1:0] exp_rdy, act_hs, req;
        bit           ehs;
        beat_t        hb;
        if (bp.size() > 0) m_axis_tready = bp.pop_front();
        else m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rand_txen) tx_enable = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < S; i++) begin
            s_axis_tvalid[i] = (srcq[i].size() > 0) &&
                               (held[i] || !rand_gaps || ($urandom_range(0, 3) != 0));
            if (srcq[i].size() > 0) begin
                s_axis_tdata[i*DW +: DW] = srcq[i][0].data;
                s_axis_tkeep[i*KW +: KW] = srcq[i][0].keep;
                s_axis_tlast[i]          = srcq[i][0].last;
                s_axis_tuser[i]          = srcq[i][0].user;
            end else begin
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tkeep[i*KW +: KW] = '0;
                s_axis_tlast[i]          = 1'b0;
                s_axis_tuser[i]          = 1'b0;
            end
        end
        #1;
        exp_rdy = '0;
        if (m_busy && (!mo_valid || m_axis_tready)) exp_rdy[m_owner] = 1'b1;
        check("grant_valid", 64'(grant_valid), 64'(m_busy));
        if (m_busy) check("grant_index", 64'(grant_index), 64'(m_owner));
        check("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(mo_valid));
        if (mo_valid) begin
            check("m_tdata", m_axis_tdata, mo.data);
            check("m_tkeep", 64'(m_axis_tkeep), 64'(mo.keep));
            check("m_tlast", 64'(m_axis_tlast), 64'(mo.last));
            check("m_tuser", 64'(m_axis_tuser), 64'(mo.user));
        end
        check("frame_count", 64'(frame_count), 64'(exp_fc));
        req    = s_axis_tvalid;
        act_hs = s_axis_tvalid & s_axis_tready;
        ehs    = |(req & exp_rdy);
        hb     = '0;
        if (ehs) hb = srcq[m_owner][0];
        if (mo_valid && m_axis_tready) begin
            out_beats++;
            if (mo.last) exp_fc = exp_fc + 32'd1;
        end
        if (ehs) begin
            mo_valid = 1'b1;
            mo       = hb;
        end else if (m_axis_tready) begin
            mo_valid = 1'b0;
        end
        if (!m_busy) begin
            if (tx_enable && (|req)) begin
                m_owner = rr_pick(m_last, req);
                m_last  = m_owner;
                m_busy  = 1'b1;
                grant_log.push_back(m_owner);
            end
        end else if (ehs && hb.last) begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        for (int i = 0; i < S; i++) begin
            if (act_hs[i]) void'(srcq[i].pop_front());
            held[i] = s_axis_tvalid[i] && !act_hs[i];
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((any_q() || m_busy || mo_valid) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 64'(n >= budget), 64'(0));
    endtask

    initial begin
        int gs, base, n;
        int exp_o [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        tx_enable = 1'b1;
        m_axis_tready = 1'b1;
        rand_rdy = 1'b0;
        rand_gaps = 1'b0;
        rand_txen = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset then idle
        repeat (3) cycle();

        // fairness: 0,1,2,3,0
        gs = grant_log.size();
        load(0, 3); load(1, 3); load(2, 3); load(3, 3); load(0, 3);
        drain(200);
        check("fair_cnt", 64'(grant_log.size() - gs), 64'(5));
        if (grant_log.size() >= gs + 5)
            for (int k = 0; k < 5; k++) check("fair_order", 64'(grant_log[gs+k]), 64'(exp_o[k]));
        check("fair_fc", 64'(frame_count), 64'(5));

        // pointer rotation: after source 2, sources 2 and 0 -> 0 then 2
        load(2, 2);
        drain(50);
        gs = grant_log.size();
        load(2, 2); load(0, 2);
        drain(50);
        check("rot_first", 64'(grant_log[gs]), 64'(0));
        check("rot_second", 64'(grant_log[gs+1]), 64'(2));

        // backpressure on a 4-beat frame from source 1
        base = out_beats;
        load(1, 4);
        bp = '{1, 1, 0, 0, 1, 1, 0, 1};
        drain(50);
        check("bp_beats", 64'(out_beats - base), 64'(4));

        // tx_enable drop mid-frame with source 3 waiting
        base = out_beats;
        gs = grant_log.size();
        load(2, 5); load(3, 1);
        n = 0;
        while (out_beats < base + 2 && n < 50) begin cycle(); n++; end
        check("txen_wait_timeout", 64'(n >= 50), 64'(0));
        tx_enable = 1'b0;
        n = 0;
        while ((m_busy || mo_valid) && n < 50) begin cycle(); n++; end
        repeat (4) cycle();
        check("txen_beats", 64'(out_beats - base), 64'(5));
        check("txen_pending", 64'(srcq[3].size()), 64'(1));
        check("txen_gv", 64'(grant_valid), 64'(0));
        tx_enable = 1'b1;
        drain(50);
        check("txen_next", 64'(grant_log[grant_log.size()-1]), 64'(3));

        // randomized traffic
        rand_rdy = 1'b1; rand_gaps = 1'b1; rand_txen = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < S; s++)
                if ($urandom_range(0, 2) != 0) load(s, $urandom_range(1, 5));
            drain(400);
        end
        rand_rdy = 1'b0; rand_gaps = 1'b0; rand_txen = 1'b0;
        tx_enable = 1'b1;
        repeat (2) cycle();

        // frame_count wrap
        force dut.frame_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.frame_count_q;
        exp_fc = 32'hFFFF_FFFE;
        load(0, 1); load(1, 1);
        drain(50);
        check("fc_wrap", 64'(frame_count), 64'(0));
        load(2, 1);
        drain(50);
        check("fc_after_wrap", 64'(frame_count), 64'(1));

        // asynchronous reset mid-frame
        load(0, 6);
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_m_tdata", m_axis_tdata, 64'(0));
        check("rst_m_tkeep", 64'(m_axis_tkeep), 64'(0));
        check("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
        check("rst_m_tuser", 64'(m_axis_tuser), 64'(0));
        check("rst_s_tready", 64'(s_axis_tready), 64'(0));
        check("rst_grant_valid", 64'(grant_valid), 64'(0));
        check("rst_grant_index", 64'(grant_index), 64'(0));
        check("rst_frame_count", 64'(frame_count), 64'(0));
        @(negedge clk);
        clear_all();
        rst = 1'b0;
        repeat (2) cycle();
        load(1, 2); load(0, 2);
        gs = grant_log.size();
        drain(50);
        check("post_rst_first", 64'(grant_log[gs]), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
